// File: rtl/pulse_window_counter_pkg.sv
// Shared types and default widths for the pulse window counter.
// The FSM encoding is fixed so the downstream FSM extraction sees a stable state set.
package pwc_pkg;

  localparam int PWC_CNT_W_DEF = 8;
  localparam int PWC_WIN_W_DEF = 8;

  typedef enum logic [1:0] {
    PWC_IDLE  = 2'd0,
    PWC_COUNT = 2'd1,
    PWC_HOLD  = 2'd2
  } pwc_state_t;

endpackage

// File: rtl/pulse_window_counter_if.sv
// Result handshake bus: the counter drives the result side (master);
// the consumer returns cnt_ready (slave).
interface pulse_window_counter_if
  import pwc_pkg::*;
#(
  parameter int CNT_W = PWC_CNT_W_DEF
) ();

  logic [CNT_W-1:0] cnt_out;
  logic             cnt_valid;
  logic             cnt_ready;
  logic             overflow;

  modport master (
    output cnt_out,
    output cnt_valid,
    output overflow,
    input  cnt_ready
  );

  modport slave (
    input  cnt_out,
    input  cnt_valid,
    input  overflow,
    output cnt_ready
  );

endinterface

// File: rtl/pulse_window_counter_sat_counter.sv
// Saturating up-counter with synchronous clear.
// sat_hit flags an increment requested while the count is already at its maximum.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         sat_hit
);

  localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

  logic [W-1:0] value_d;
  logic [W-1:0] value_q;

  // Next count: clear has priority, increments stop at the maximum.
  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = {W{1'b0}};
    end else if (inc && (value_q != MAX_VAL)) begin
      value_d = value_q + W'(1);
    end else begin
      value_d = value_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= {W{1'b0}};
    end else begin
      value_q <= value_d;
    end
  end

  assign value   = value_q;
  assign sat_hit = inc & ~clr & (value_q == MAX_VAL);

endmodule

// File: rtl/pulse_window_counter.sv
// Counts pulse_in-high cycles over a programmable window and reports the total
// on a valid/ready result bus with a sticky overflow flag. All outputs are flops.
module pulse_window_counter
  import pwc_pkg::*;
#(
  parameter int CNT_W = PWC_CNT_W_DEF,
  parameter int WIN_W = PWC_WIN_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pulse_in,
  input  logic                    start,
  input  logic [WIN_W-1:0]        win_len,
  input  logic                    abort,
  output logic                    busy,
  pulse_window_counter_if.master  res
);

  pwc_state_t       state_d,     state_q;
  logic [WIN_W-1:0] remain_d,    remain_q;
  logic [CNT_W-1:0] cnt_out_d,   cnt_out_q;
  logic             overflow_d,  overflow_q;
  logic             busy_d,      busy_q;
  logic             cnt_valid_d, cnt_valid_q;

  logic             cnt_clr_s;
  logic             cnt_inc_s;
  logic [CNT_W-1:0] cnt_val_s;
  logic             sat_hit_s;
  logic [CNT_W-1:0] cnt_next_s;

  // Counter controls are decoded outside the FSM block so sat_hit does not loop back into it.
  assign cnt_clr_s  = (state_q == PWC_IDLE)  & ~abort & start;
  assign cnt_inc_s  = (state_q == PWC_COUNT) & ~abort & pulse_in;
  assign cnt_next_s = (cnt_inc_s && !sat_hit_s) ? (cnt_val_s + CNT_W'(1)) : cnt_val_s;

  sat_counter #(
    .W (CNT_W)
  ) u_pulse_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr_s),
    .inc     (cnt_inc_s),
    .value   (cnt_val_s),
    .sat_hit (sat_hit_s)
  );

  // FSM next-state and datapath updates; abort takes priority in every state.
  always_comb begin
    state_d    = state_q;
    remain_d   = remain_q;
    cnt_out_d  = cnt_out_q;
    overflow_d = overflow_q;
    case (state_q)
      PWC_IDLE: begin
        if (abort) begin
          state_d = PWC_IDLE;
        end else if (start) begin
          overflow_d = 1'b0;
          remain_d   = win_len;
          if (win_len == {WIN_W{1'b0}}) begin
            state_d   = PWC_HOLD;
            cnt_out_d = {CNT_W{1'b0}};
          end else begin
            state_d = PWC_COUNT;
          end
        end else begin
          state_d = PWC_IDLE;
        end
      end
      PWC_COUNT: begin
        if (abort) begin
          state_d = PWC_IDLE;
        end else begin
          remain_d = remain_q - WIN_W'(1);
          if (sat_hit_s) begin
            overflow_d = 1'b1;
          end else begin
            overflow_d = overflow_q;
          end
          // Last sampled cycle: publish the count including this cycle's pulse.
          if (remain_q == WIN_W'(1)) begin
            state_d   = PWC_HOLD;
            cnt_out_d = cnt_next_s;
          end else begin
            state_d = PWC_COUNT;
          end
        end
      end
      PWC_HOLD: begin
        if (abort || res.cnt_ready) begin
          state_d = PWC_IDLE;
        end else begin
          state_d = PWC_HOLD;
        end
      end
      default: begin
        state_d = PWC_IDLE;
      end
    endcase
    busy_d      = (state_d != PWC_IDLE);
    cnt_valid_d = (state_d == PWC_HOLD);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PWC_IDLE;
      remain_q    <= {WIN_W{1'b0}};
      cnt_out_q   <= {CNT_W{1'b0}};
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      cnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      cnt_out_q   <= cnt_out_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
      cnt_valid_q <= cnt_valid_d;
    end
  end

  assign busy          = busy_q;
  assign res.cnt_out   = cnt_out_q;
  assign res.cnt_valid = cnt_valid_q;
  assign res.overflow  = overflow_q;

endmodule

// File: tb/tb_pulse_window_counter.sv
// Directed bench for pulse_window_counter: an 8-bit and a 2-bit instance share the stimulus;
// outputs are sampled on the falling edge, inputs change right after sampling.
module tb_pulse_window_counter;

  logic       clk;
  logic       rst_n;
  logic       pulse_in;
  logic       start;
  logic [7:0] win_len;
  logic       abort;
  logic       rdy;
  logic       busy8;
  logic       busy2;

  int vectors;
  int miscompares;

  pulse_window_counter_if #(.CNT_W(8)) bus8 ();
  pulse_window_counter_if #(.CNT_W(2)) bus2 ();

  assign bus8.cnt_ready = rdy;
  assign bus2.cnt_ready = rdy;

  pulse_window_counter #(.CNT_W(8), .WIN_W(8)) dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .pulse_in (pulse_in),
    .start    (start),
    .win_len  (win_len),
    .abort    (abort),
    .busy     (busy8),
    .res      (bus8.master)
  );

  pulse_window_counter #(.CNT_W(2), .WIN_W(8)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .pulse_in (pulse_in),
    .start    (start),
    .win_len  (win_len),
    .abort    (abort),
    .busy     (busy2),
    .res      (bus2.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_win(input logic [7:0] len);
    start   = 1'b1;
    win_len = len;
    tick();
    start   = 1'b0;
  endtask

  task automatic run(input int len, input logic [15:0] pat);
    for (int i = 0; i < len; i++) begin
      pulse_in = pat[i];
      tick();
    end
    pulse_in = 1'b0;
  endtask

  task automatic accept();
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    chk("accept_valid", {31'd0, bus8.cnt_valid}, 32'd0);
    chk("accept_busy", {31'd0, busy8}, 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n    = 1'b0;
    pulse_in = 1'b0;
    start    = 1'b0;
    win_len  = 8'd0;
    abort    = 1'b0;
    rdy      = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_valid", {31'd0, bus8.cnt_valid}, 32'd0);
    chk("rst_cnt", {24'd0, bus8.cnt_out}, 32'd0);
    chk("rst_ovf", {31'd0, bus8.overflow}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Asynchronous reset in the middle of a 10-cycle window.
    start_win(8'd10);
    pulse_in = 1'b1;
    tick();
    tick();
    chk("mid_busy", {31'd0, busy8}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy8}, 32'd0);
    chk("arst_valid", {31'd0, bus8.cnt_valid}, 32'd0);
    chk("arst_cnt", {24'd0, bus8.cnt_out}, 32'd0);
    chk("arst_ovf", {31'd0, bus8.overflow}, 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    pulse_in = 1'b0;
    start_win(8'd3);
    run(3, 16'b011);
    chk("post_rst_valid", {31'd0, bus8.cnt_valid}, 32'd1);
    chk("post_rst_cnt", {24'd0, bus8.cnt_out}, 32'd2);
    accept();

    // Window of 5 with alternating pulses, then a held result.
    start_win(8'd5);
    run(4, 16'b0101);
    chk("w5_not_yet", {31'd0, bus8.cnt_valid}, 32'd0);
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    chk("w5_valid", {31'd0, bus8.cnt_valid}, 32'd1);
    chk("w5_cnt", {24'd0, bus8.cnt_out}, 32'd3);
    chk("w5_ovf", {31'd0, bus8.overflow}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_valid", {31'd0, bus8.cnt_valid}, 32'd1);
      chk("hold_cnt", {24'd0, bus8.cnt_out}, 32'd3);
    end
    accept();
    chk("after_accept_cnt", {24'd0, bus8.cnt_out}, 32'd3);

    // Saturation on the 2-bit instance.
    start_win(8'd6);
    run(6, 16'h003f);
    chk("sat2_cnt", {30'd0, bus2.cnt_out}, 32'd3);
    chk("sat2_ovf", {31'd0, bus2.overflow}, 32'd1);
    chk("sat8_cnt", {24'd0, bus8.cnt_out}, 32'd6);
    chk("sat8_ovf", {31'd0, bus8.overflow}, 32'd0);
    accept();
    chk("sat2_ovf_sticky", {31'd0, bus2.overflow}, 32'd1);
    start_win(8'd6);
    chk("sat2_ovf_clr", {31'd0, bus2.overflow}, 32'd0);
    run(6, 16'h0000);
    chk("zero2_valid", {31'd0, bus2.cnt_valid}, 32'd1);
    chk("zero2_cnt", {30'd0, bus2.cnt_out}, 32'd0);
    chk("zero2_ovf", {31'd0, bus2.overflow}, 32'd0);
    accept();

    // Zero-length window, then start held high and win_len changed during a window of 4.
    start_win(8'd0);
    chk("w0_valid", {31'd0, bus8.cnt_valid}, 32'd1);
    chk("w0_cnt", {24'd0, bus8.cnt_out}, 32'd0);
    accept();
    start   = 1'b1;
    win_len = 8'd4;
    tick();
    win_len = 8'd9;
    for (int i = 0; i < 3; i++) begin
      pulse_in = (i != 1);
      tick();
    end
    chk("w4_not_yet", {31'd0, bus8.cnt_valid}, 32'd0);
    pulse_in = 1'b1;
    tick();
    start    = 1'b0;
    pulse_in = 1'b0;
    chk("w4_valid", {31'd0, bus8.cnt_valid}, 32'd1);
    chk("w4_cnt", {24'd0, bus8.cnt_out}, 32'd3);
    accept();

    // Abort on cycle 2 of an 8-cycle window keeps the previous result of 7.
    start_win(8'd7);
    run(7, 16'h007f);
    chk("w7_cnt", {24'd0, bus8.cnt_out}, 32'd7);
    accept();
    start_win(8'd8);
    pulse_in = 1'b1;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy8}, 32'd0);
    chk("abort_valid", {31'd0, bus8.cnt_valid}, 32'd0);
    chk("abort_cnt", {24'd0, bus8.cnt_out}, 32'd7);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("abort_no_valid", {31'd0, bus8.cnt_valid}, 32'd0);
    end
    pulse_in = 1'b0;
    chk("abort_cnt_kept", {24'd0, bus8.cnt_out}, 32'd7);

    // Pulse only on the last window cycle, without and with abort.
    start_win(8'd4);
    run(4, 16'b1000);
    chk("last_valid", {31'd0, bus8.cnt_valid}, 32'd1);
    chk("last_cnt", {24'd0, bus8.cnt_out}, 32'd1);
    accept();
    start_win(8'd4);
    run(3, 16'b000);
    pulse_in = 1'b1;
    abort    = 1'b1;
    tick();
    abort    = 1'b0;
    pulse_in = 1'b0;
    chk("last_abort_busy", {31'd0, busy8}, 32'd0);
    chk("last_abort_valid", {31'd0, bus8.cnt_valid}, 32'd0);
    chk("last_abort_cnt", {24'd0, bus8.cnt_out}, 32'd1);
    tick();
    chk("last_abort_still", {31'd0, bus8.cnt_valid}, 32'd0);

    // Abort overrides start in IDLE; abort releases HOLD.
    start   = 1'b1;
    abort   = 1'b1;
    win_len = 8'd3;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("idle_abort_busy", {31'd0, busy8}, 32'd0);
    start_win(8'd1);
    run(1, 16'b1);
    chk("w1_valid", {31'd0, bus8.cnt_valid}, 32'd1);
    chk("w1_cnt", {24'd0, bus8.cnt_out}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("hold_abort_valid", {31'd0, bus8.cnt_valid}, 32'd0);
    chk("hold_abort_cnt", {24'd0, bus8.cnt_out}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pulse_window_counter.md
Name: pulse_window_counter

Overview:
- Downstream consumer of the single-bit toggling state-machine output in the FSM-extraction test set.
- Counts the cycles in which pulse_in is high over a programmable window of clock cycles.
- Presents the result on a valid/ready handshake with a sticky overflow flag.
- Gives yosys a second FSM (IDLE/COUNT/HOLD) plus saturating counters to exercise fsm/opt_dff passes downstream of the toggler.

Parameters:
- CNT_W, 8, width of pulse count and cnt_out.
- WIN_W, 8, width of win_len and internal window down-counter.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pulse_in  input  1  pulse stream from upstream toggler output; sampled each COUNT cycle.
- start  input  1  request a new window; honoured only in IDLE.
- win_len  input  WIN_W  window length in cycles; latched when start is accepted.
- abort  input  1  synchronous cancel; highest priority after reset.
- busy  output  1  high in COUNT and HOLD.
- cnt_out  output  CNT_W  pulse count of last completed window; stable while cnt_valid.
- cnt_valid  output  1  result available (HOLD state).
- cnt_ready  input  1  downstream accepts result.
- overflow  output  1  count saturated during the reported window.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - busy, cnt_valid and overflow = 0.
  - cnt_out, count and window counter = 0.
- IDLE:
  - start=1 → COUNT next cycle.
  - Latch win_len into the remaining-cycles counter.
  - Clear count and overflow.
  - cnt_out retains its previous value but is not valid.
- IDLE, start=1 with win_len=0 → HOLD directly: cnt_out=0, overflow=0, cnt_valid=1 next cycle.
- COUNT, per cycle:
  - If pulse_in=1, count += 1, saturating at 2^CNT_W-1.
  - An increment attempted at saturation sets overflow (sticky until next accepted start).
  - remaining -= 1.
- COUNT, end of window:
  - When remaining==1, that cycle is the last sampled one.
  - Next cycle: state=HOLD, cnt_out = final count including the last cycle's pulse, cnt_valid=1.
- Window timing:
  - Exactly win_len sampled cycles.
  - The first sampled cycle is the cycle after start is accepted.
  - Latency from start to cnt_valid = win_len+1 cycles.
- start while busy: ignored, no effect on count or window.
- Changes to win_len mid-window: ignored, the latched value is used.
- HOLD:
  - cnt_valid=1 with cnt_out/overflow held stable.
  - cnt_valid & cnt_ready → IDLE next cycle; cnt_valid drops.
  - start in the same cycle as acceptance is ignored; a new start must be presented in IDLE.
- abort=1 in COUNT or HOLD:
  - → IDLE next cycle; busy and cnt_valid drop.
  - count is discarded; cnt_out is unchanged (it keeps the previous completed result).
  - abort in IDLE: no effect; abort overrides start.
- Simultaneous events in COUNT:
  - abort wins over end-of-window.
  - pulse_in on the last window cycle is counted.
- Registers: all outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package pwc_pkg:
  - typedef enum logic [1:0] {PWC_IDLE, PWC_COUNT, PWC_HOLD} pwc_state_t.
  - Localparam defaults for CNT_W/WIN_W.
- Sub-module sat_counter:
  - Parameterised width.
  - Inputs clr and inc; outputs value and sat_hit.
  - Instantiated once for the pulse count.
- The window down-counter stays inline in the FSM.

Test Plan:
- Reset mid-COUNT (rst_n low during window of 10) → all outputs 0 immediately, state IDLE; post-reset start with win_len=3 works normally.
- start, win_len=5, pulse_in alternating 1,0,1,0,1 → cnt_valid rises 6 cycles after start, cnt_out=3, overflow=0; held 4 cycles with cnt_ready=0, stable; cnt_ready=1 → cnt_valid=0 next cycle.
- CNT_W=2, win_len=6, pulse_in=1 throughout → cnt_out=3, overflow=1; next window with pulse_in=0 → cnt_out=0, overflow=0.
- win_len=0 start → cnt_valid=1 next cycle, cnt_out=0; start asserted again during COUNT of a win_len=4 window → ignored, valid after exactly 5 cycles.
- abort on cycle 2 of win_len=8 with prior result 7 → busy=0 next cycle, cnt_valid never asserts, cnt_out stays 7.
- pulse_in=1 only on last window cycle with abort=0, win_len=4 → cnt_out=1; same with abort on that cycle → IDLE, no valid.
